// File: rtl/encoder_pkg.sv
`default_nettype none
// encoder_pkg: types and constants shared by the encoder input filter and the position decoder.
package encoder_pkg;

    typedef logic [1:0] quad_state;  // {a, b}

    typedef enum logic {
        STABLE  = 1'b0,
        PENDING = 1'b1
    } filter_state_t;

    localparam int GLITCH_CNT_W = 8;

endpackage
`default_nettype wire

// File: rtl/encoder_debounce_channel.sv
`default_nettype none
// encoder_debounce_channel: synchroniser plus STABLE/PENDING debounce FSM for one encoder pin.
// The reject pulse exists only when ENCODER_FILTER_GLITCH_CNT_EN is defined.
module encoder_debounce_channel
    import encoder_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 8
) (
    input  logic clock,
    input  logic a_reset,
    input  logic raw,
    output logic filtered,
    output logic commit
`ifdef ENCODER_FILTER_GLITCH_CNT_EN
    ,
    output logic reject
`endif
);

    localparam int               CNT_W    = $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   synced;
    logic                   differs;
    logic                   at_last;
    filter_state_t          state;
    logic [CNT_W-1:0]       cnt;

    assign synced  = sync_q[SYNC_STAGES-1];
    assign differs = (synced != filtered);
    assign at_last = (cnt == CNT_LAST);
    assign commit  = (state == PENDING) && differs && at_last;
`ifdef ENCODER_FILTER_GLITCH_CNT_EN
    assign reject  = (state == PENDING) && !differs;
`endif

    always_ff @(posedge clock or negedge a_reset) begin
        if (!a_reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
        end
    end

    // cnt counts how many consecutive samples the new level has been seen.
    always_ff @(posedge clock or negedge a_reset) begin
        if (!a_reset) begin
            state    <= STABLE;
            cnt      <= '0;
            filtered <= 1'b0;
        end else begin
            case (state)
                STABLE: begin
                    if (differs) begin
                        state <= PENDING;
                        cnt   <= CNT_W'(1);
                    end
                end
                PENDING: begin
                    if (!differs) begin
                        state <= STABLE;
                        cnt   <= '0;
                    end else if (at_last) begin
                        filtered <= synced;
                        state    <= STABLE;
                        cnt      <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= STABLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/encoder_input_filter.sv
`default_nettype none
// encoder_input_filter: debounced quadrature inputs with a shared edge strobe.
// ENCODER_FILTER_GLITCH_CNT_EN adds the saturating glitch_count output.
module encoder_input_filter
    import encoder_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 8
) (
    input  logic                    clock,
    input  logic                    a_reset,
    input  logic                    encoder_a,
    input  logic                    encoder_b,
    output logic                    filtered_a,
    output logic                    filtered_b,
    output logic                    edge_strobe
`ifdef ENCODER_FILTER_GLITCH_CNT_EN
    ,
    output logic [GLITCH_CNT_W-1:0] glitch_count
`endif
);

    quad_state filt;
    logic      commit_a;
    logic      commit_b;
`ifdef ENCODER_FILTER_GLITCH_CNT_EN
    logic      reject_a;
    logic      reject_b;
`endif

    encoder_debounce_channel #(
        .SYNC_STAGES  (SYNC_STAGES),
        .STABLE_CYCLES(STABLE_CYCLES)
    ) u_chan_a (
        .clock   (clock),
        .a_reset (a_reset),
        .raw     (encoder_a),
        .filtered(filt[1]),
        .commit  (commit_a)
`ifdef ENCODER_FILTER_GLITCH_CNT_EN
        ,
        .reject  (reject_a)
`endif
    );

    encoder_debounce_channel #(
        .SYNC_STAGES  (SYNC_STAGES),
        .STABLE_CYCLES(STABLE_CYCLES)
    ) u_chan_b (
        .clock   (clock),
        .a_reset (a_reset),
        .raw     (encoder_b),
        .filtered(filt[0]),
        .commit  (commit_b)
`ifdef ENCODER_FILTER_GLITCH_CNT_EN
        ,
        .reject  (reject_b)
`endif
    );

    assign filtered_a = filt[1];
    assign filtered_b = filt[0];

    // Registered on the same edge as the filtered update, so it aligns with the new value.
    always_ff @(posedge clock or negedge a_reset) begin
        if (!a_reset) begin
            edge_strobe <= 1'b0;
        end else begin
            edge_strobe <= commit_a | commit_b;
        end
    end

`ifdef ENCODER_FILTER_GLITCH_CNT_EN
    localparam int SUM_W = GLITCH_CNT_W + 1;

    logic [SUM_W-1:0] glitch_sum;

    assign glitch_sum = {1'b0, glitch_count} + SUM_W'(reject_a) + SUM_W'(reject_b);

    always_ff @(posedge clock or negedge a_reset) begin
        if (!a_reset) begin
            glitch_count <= '0;
        end else if (glitch_sum[GLITCH_CNT_W]) begin
            glitch_count <= '1;
        end else begin
            glitch_count <= glitch_sum[GLITCH_CNT_W-1:0];
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_encoder_input_filter.sv
`default_nettype none
// tb_encoder_input_filter: directed stimulus with a strobe scoreboard for encoder_input_filter.
module tb_encoder_input_filter;

    logic       clock = 1'b0;
    logic       a_reset;
    logic       encoder_a;
    logic       encoder_b;
    logic       filtered_a;
    logic       filtered_b;
    logic       edge_strobe;
`ifdef ENCODER_FILTER_GLITCH_CNT_EN
    logic [7:0] glitch_count;
`endif

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        int   edge_no;
        logic fa;
        logic fb;
    } exp_t;

    exp_t exp_q[$];

    encoder_input_filter dut (
        .clock       (clock),
        .a_reset     (a_reset),
        .encoder_a   (encoder_a),
        .encoder_b   (encoder_b),
        .filtered_a  (filtered_a),
        .filtered_b  (filtered_b),
        .edge_strobe (edge_strobe)
`ifdef ENCODER_FILTER_GLITCH_CNT_EN
        ,
        .glitch_count(glitch_count)
`endif
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
        checks++;
        assert (obs === req) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Called at posedge+1: the next edge registers the new level, commit lands 9 edges later.
    task automatic expect_commit(input logic fa, input logic fb);
        exp_t e;
        e.edge_no = cyc + 10;
        e.fa      = fa;
        e.fb      = fb;
        exp_q.push_back(e);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick(1);
        check(tag, exp_q.size(), 0);
    endtask

    // Every strobe must match the oldest expected commit in timing and value.
    always @(posedge clock) begin
        #1;
        if (edge_strobe === 1'b1) begin
            check("strobe_expected", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check("strobe_edge", cyc, e.edge_no);
                check("strobe_fa", filtered_a, e.fa);
                check("strobe_fb", filtered_b, e.fb);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0] seq [4];
        seq = '{2'b10, 2'b11, 2'b01, 2'b00};

        // Reset release with both inputs high.
        a_reset   = 1'b0;
        encoder_a = 1'b1;
        encoder_b = 1'b1;
        tick(3);
        check("reset_fa", filtered_a, 0);
        check("reset_fb", filtered_b, 0);
        check("reset_strobe", edge_strobe, 0);
`ifdef ENCODER_FILTER_GLITCH_CNT_EN
        check("reset_glitch", glitch_count, 0);
`endif
        a_reset = 1'b1;
        expect_commit(1'b1, 1'b1);
        tick(9);
        check("latency_not_early", filtered_a, 0);
        tick(1);
        check("latency_fa", filtered_a, 1);
        check("latency_fb", filtered_b, 1);
        check("latency_strobe", edge_strobe, 1);
        tick(1);
        check("strobe_one_cycle", edge_strobe, 0);
        drain("drain_reset_release");

        // Back to 00, then a 5-cycle glitch on A.
        {encoder_a, encoder_b} = 2'b00;
        expect_commit(1'b0, 1'b0);
        tick(20);
        drain("drain_to_zero");
        encoder_a = 1'b1;
        tick(5);
        encoder_a = 1'b0;
        tick(20);
        check("short_pulse_fa", filtered_a, 0);
`ifdef ENCODER_FILTER_GLITCH_CNT_EN
        check("short_pulse_glitch", glitch_count, 1);
`endif

        // Threshold: 7 cycles rejected, 8 cycles committed (and the fall commits too).
        encoder_a = 1'b1;
        tick(7);
        encoder_a = 1'b0;
        tick(20);
        check("thresh7_fa", filtered_a, 0);
`ifdef ENCODER_FILTER_GLITCH_CNT_EN
        check("thresh7_glitch", glitch_count, 2);
`endif
        encoder_a = 1'b1;
        expect_commit(1'b1, 1'b0);
        tick(8);
        encoder_a = 1'b0;
        expect_commit(1'b0, 1'b0);
        tick(20);
        drain("drain_thresh8");

        // Simultaneous glitch on both channels.
        {encoder_a, encoder_b} = 2'b11;
        tick(4);
        {encoder_a, encoder_b} = 2'b00;
        tick(20);
        check("dual_glitch_fa", filtered_a, 0);
        check("dual_glitch_fb", filtered_b, 0);
`ifdef ENCODER_FILTER_GLITCH_CNT_EN
        check("dual_glitch_count", glitch_count, 4);
`endif

        // Quadrature walk.
        for (int i = 0; i < 4; i++) begin
            {encoder_a, encoder_b} = seq[i];
            expect_commit(seq[i][1], seq[i][0]);
            tick(10);
            check("quad_step", {filtered_a, filtered_b}, seq[i]);
            tick(10);
        end
        drain("drain_quad");
`ifdef ENCODER_FILTER_GLITCH_CNT_EN
        check("quad_glitch", glitch_count, 4);
`endif

        // Saturation: 300 three-cycle glitches on B.
        for (int i = 0; i < 300; i++) begin
            encoder_b = 1'b1;
            tick(3);
            encoder_b = 1'b0;
            tick(3);
`ifdef ENCODER_FILTER_GLITCH_CNT_EN
            if (i == 99) check("sat_mid_count", glitch_count, 104);
`endif
        end
        tick(5);
        check("sat_fb", filtered_b, 0);
`ifdef ENCODER_FILTER_GLITCH_CNT_EN
        check("sat_count", glitch_count, 255);
`endif

        // Commit B, then reset while A is pending.
        encoder_b = 1'b1;
        expect_commit(1'b0, 1'b1);
        tick(12);
        drain("drain_b_high");
        check("pre_reset_fb", filtered_b, 1);
        encoder_a = 1'b1;
        tick(5);
        a_reset = 1'b0;
        #1;
        check("async_reset_fa", filtered_a, 0);
        check("async_reset_fb", filtered_b, 0);
        check("async_reset_strobe", edge_strobe, 0);
`ifdef ENCODER_FILTER_GLITCH_CNT_EN
        check("async_reset_glitch", glitch_count, 0);
`endif
        {encoder_a, encoder_b} = 2'b00;
        tick(3);
        a_reset = 1'b1;
        tick(20);
        check("post_reset_fa", filtered_a, 0);
        check("post_reset_fb", filtered_b, 0);
`ifdef ENCODER_FILTER_GLITCH_CNT_EN
        check("post_reset_glitch", glitch_count, 0);
`endif
        drain("drain_final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
